// File: rtl/smc_in_loader.sv
// Serial-to-parallel loader for the SMC datapath: assembles N_DEV (W, V_GS, V_DS)
// beats into a parallel frame and holds it under a valid/ready handshake.
module smc_in_loader #(
  parameter int N_DEV = 6,
  parameter int DW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode_in,
  input  logic [DW-1:0]       W_in,
  input  logic [DW-1:0]       V_GS_in,
  input  logic [DW-1:0]       V_DS_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          mode,
  output logic [N_DEV*DW-1:0] W_bus,
  output logic [N_DEV*DW-1:0] V_GS_bus,
  output logic [N_DEV*DW-1:0] V_DS_bus,
  output logic                frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  localparam logic [2:0] LAST = 3'(N_DEV - 1);

  state_t     state, state_nxt;
  logic [2:0] count, count_nxt;
  logic       accept;
  logic       handshake;
  logic       gap;

  always_comb begin
    in_ready  = (state != HOLD);
    accept    = in_valid && in_ready;
    handshake = out_valid && out_ready;
    state_nxt = state;
    count_nxt = count;
    gap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LOAD;
          count_nxt = 3'd1;
        end
      end
      LOAD: begin
        if (!in_valid) begin
          gap       = 1'b1;
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (count == LAST) begin
          count_nxt = '0;
          state_nxt = HOLD;
        end else begin
          count_nxt = count + 3'd1;
        end
      end
      HOLD: begin
        if (handshake) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out_valid is registered off HOLD, so it rises one cycle after the last
  // beat edge; with the handshake cycle this gives an N_DEV+2 frame period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      frame_err <= gap;
      out_valid <= (state == HOLD) && !handshake;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= '0;
      W_bus    <= '0;
      V_GS_bus <= '0;
      V_DS_bus <= '0;
    end else if (accept) begin
      if (state == IDLE) mode <= mode_in;
      for (int unsigned i = 0; i < N_DEV; i++) begin
        if (count == 3'(i)) begin
          W_bus[DW*i +: DW]    <= W_in;
          V_GS_bus[DW*i +: DW] <= V_GS_in;
          V_DS_bus[DW*i +: DW] <= V_DS_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_smc_in_loader.sv
// Self-checking bench for smc_in_loader: scenario tasks with a frame scoreboard.
module tb_smc_in_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  mode_in = '0;
  logic [2:0]  W_in = '0;
  logic [2:0]  V_GS_in = '0;
  logic [2:0]  V_DS_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  mode;
  logic [17:0] W_bus;
  logic [17:0] V_GS_bus;
  logic [17:0] V_DS_bus;
  logic        frame_err;

  typedef struct packed {
    logic [1:0]  m;
    logic [17:0] w;
    logic [17:0] g;
    logic [17:0] d;
  } frame_t;

  frame_t sb[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;

  smc_in_loader #(.N_DEV(6), .DW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode_in(mode_in), .W_in(W_in), .V_GS_in(V_GS_in), .V_DS_in(V_DS_in),
    .out_valid(out_valid), .out_ready(out_ready), .mode(mode),
    .W_bus(W_bus), .V_GS_bus(V_GS_bus), .V_DS_bus(V_DS_bus),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic frame_t rand_frame();
    frame_t f;
    f.m = 2'($urandom);
    f.w = 18'($urandom);
    f.g = 18'($urandom);
    f.d = 18'($urandom);
    return f;
  endfunction

  // Drives one frame; each beat is held until accepted. t_first = cycle of beat 0.
  task automatic send_frame(input frame_t f, input logic [1:0] mode_rest, output int t_first);
    int waited;
    logic acc;
    t_first = -1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      mode_in  = (i == 0) ? f.m : mode_rest;
      W_in     = f.w[3*i +: 3];
      V_GS_in  = f.g[3*i +: 3];
      V_DS_in  = f.d[3*i +: 3];
      waited   = 0;
      do begin
        acc = in_ready;
        @(posedge clk); #1;
        waited++;
      end while (!acc && waited < 20);
      if (!acc) begin
        tests++; fails++;
        $display("FAIL beat_accept_timeout beat=%0d in_ready=%b required=1", i, in_ready);
      end
      if (i == 0) t_first = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid, frame_err, mode, W_bus, V_GS_bus, V_DS_bus} !== {1'b1, 58'd0}) begin
      fails++;
      $display("FAIL reset_state got rdy=%b vld=%b err=%b mode=%b W=%o G=%o D=%o required rdy=1 rest 0",
               in_ready, out_valid, frame_err, mode, W_bus, V_GS_bus, V_DS_bus);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    frame_t f, e;
    int t;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f.w[3*i +: 3] = 3'(i + 1);
      f.g[3*i +: 3] = 3'(i + 2);
      f.d[3*i +: 3] = 3'(i);
    end
    f.m = 2'b01;
    sb.push_back({2'b01, 18'o654321, 18'o765432, 18'o543210});
    send_frame(f, 2'b10, t);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_valid got vld=%b rdy=%b required vld=1 rdy=0", out_valid, in_ready);
    end
    tests++;
    if ({mode, W_bus, V_GS_bus, V_DS_bus} !== e) begin
      fails++;
      $display("FAIL basic_data got %h required %h", {mode, W_bus, V_GS_bus, V_DS_bus}, e);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_handshake got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    frame_t f, e;
    int t;
    out_ready = 1'b0;
    f = rand_frame();
    sb.push_back(f);
    send_frame(f, ~f.m, t);
    wait_out();
    e = sb.pop_front();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      mode_in  = ~e.m;
      W_in     = ~e.w[2:0];
      V_GS_in  = ~e.g[2:0];
      V_DS_in  = ~e.d[2:0];
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {mode, W_bus, V_GS_bus, V_DS_bus} !== e) begin
        fails++;
        $display("FAIL hold_stable cyc=%0d got vld=%b rdy=%b data=%h required vld=1 rdy=0 data=%h",
                 k, out_valid, in_ready, {mode, W_bus, V_GS_bus, V_DS_bus}, e);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {mode, W_bus, V_GS_bus, V_DS_bus} !== e) begin
      fails++;
      $display("FAIL hold_release got vld=%b rdy=%b data=%h required vld=0 rdy=1 data=%h",
               out_valid, in_ready, {mode, W_bus, V_GS_bus, V_DS_bus}, e);
    end
  endtask

  task automatic test_gap();
    frame_t f, e;
    int t;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      mode_in  = 2'b10;
      W_in     = 3'd7;
      V_GS_in  = 3'd7;
      V_DS_in  = 3'd7;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL gap_early_err got %b required 0", frame_err);
    end
    @(posedge clk); #1;
    tests++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL gap_err_pulse got err=%b vld=%b required err=1 vld=0", frame_err, out_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL gap_err_width got err=%b vld=%b required err=0 vld=0", frame_err, out_valid);
    end
    f = rand_frame();
    sb.push_back(f);
    send_frame(f, ~f.m, t);
    wait_out();
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {mode, W_bus, V_GS_bus, V_DS_bus} !== e) begin
      fails++;
      $display("FAIL gap_recover got vld=%b data=%h required vld=1 data=%h",
               out_valid, {mode, W_bus, V_GS_bus, V_DS_bus}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mode_first_beat();
    frame_t f, e;
    int t;
    out_ready = 1'b1;
    f = rand_frame();
    f.m = 2'b11;
    sb.push_back(f);
    send_frame(f, 2'b00, t);
    wait_out();
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || mode !== 2'b11 || {mode, W_bus, V_GS_bus, V_DS_bus} !== e) begin
      fails++;
      $display("FAIL mode_capture got vld=%b mode=%b data=%h required vld=1 mode=11 data=%h",
               out_valid, mode, {mode, W_bus, V_GS_bus, V_DS_bus}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    frame_t a, b, e;
    int ta, tb;
    out_ready = 1'b1;
    a = rand_frame();
    b = rand_frame();
    sb.push_back(a);
    sb.push_back(b);
    send_frame(a, ~a.m, ta);
    in_valid = 1'b1;
    mode_in  = b.m;
    W_in     = b.w[2:0];
    V_GS_in  = b.g[2:0];
    V_DS_in  = b.d[2:0];
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {mode, W_bus, V_GS_bus, V_DS_bus} !== e) begin
      fails++;
      $display("FAIL b2b_first got vld=%b data=%h required vld=1 data=%h",
               out_valid, {mode, W_bus, V_GS_bus, V_DS_bus}, e);
    end
    send_frame(b, ~b.m, tb);
    tests++;
    if (tb - ta != 8) begin
      fails++;
      $display("FAIL b2b_period got %0d required 8", tb - ta);
    end
    wait_out();
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {mode, W_bus, V_GS_bus, V_DS_bus} !== e) begin
      fails++;
      $display("FAIL b2b_second got vld=%b data=%h required vld=1 data=%h",
               out_valid, {mode, W_bus, V_GS_bus, V_DS_bus}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    int t;
    out_ready = 1'b1;
    f = rand_frame();
    f.w = 18'o654321;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      mode_in  = 2'b11;
      W_in     = f.w[3*i +: 3];
      V_GS_in  = 3'd5;
      V_DS_in  = 3'd6;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    tests++;
    if ({in_ready, out_valid, frame_err, mode, W_bus, V_GS_bus, V_DS_bus} !== {1'b1, 58'd0}) begin
      fails++;
      $display("FAIL reset_load got rdy=%b vld=%b err=%b mode=%b W=%o G=%o D=%o required rdy=1 rest 0",
               in_ready, out_valid, frame_err, mode, W_bus, V_GS_bus, V_DS_bus);
    end
    out_ready = 1'b0;
    f = rand_frame();
    f.w[2:0] = 3'd1;
    send_frame(f, ~f.m, t);
    wait_out();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold_setup got vld=%b required 1", out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, frame_err, mode, W_bus, V_GS_bus, V_DS_bus} !== {1'b1, 58'd0}) begin
      fails++;
      $display("FAIL reset_hold got rdy=%b vld=%b err=%b mode=%b W=%o G=%o D=%o required rdy=1 rest 0",
               in_ready, out_valid, frame_err, mode, W_bus, V_GS_bus, V_DS_bus);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_mode_first_beat();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
